dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-memory port (Address/DataWr/DMWr/DMCtrl/DataRd) between two requesters:
//  m0 = core load/store unit, m1 = DMA/debug loader. Round-robin arbitration, registered request
//  capture, alignment/range/opcode checking, and one-cycle response pulse per transaction.
//  Sits between the LSU/DMA and DataMemory; DataMemory itself is unchanged.
// PARAMETERS
//  MEM_WORDS  256  word depth of DataMemory; byte addresses >= MEM_WORDS*4 are out of range
//  XLEN       32   address and data width
// PORTS
//  clk        in   1     single clock, all state updates on rising edge
//  rst_n      in   1     synchronous, active-low reset
//  mN_req     in   1     (N=0,1) request; held with fields stable until mN_gnt
//  mN_we      in   1     1 = store, 0 = load
//  mN_ctrl    in   3     DMCtrl code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  mN_addr    in   XLEN  byte address
//  mN_wdata   in   XLEN  store data (low byte/half used for B/H)
//  mN_gnt     out  1     combinational accept; fields captured at this edge
//  mN_rvalid  out  1     one-cycle response pulse (loads and stores)
//  mN_rdata   out  XLEN  load result, valid with rvalid; 0 for stores and errors
//  mN_err     out  1     valid with rvalid; misaligned/out-of-range/illegal ctrl
//  mem_addr   out  XLEN  to DataMemory.Address
//  mem_wdata  out  XLEN  to DataMemory.DataWr
//  mem_wr     out  1     to DataMemory.DMWr
//  mem_ctrl   out  3     to DataMemory.DMCtrl
//  mem_rdata  in   XLEN  from DataMemory.DataRd (combinational read)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, rr_last=1 (m0 wins first tie), all gnt/rvalid/err=0,
//   rdata=0, mem_addr=0, mem_wdata=0, mem_ctrl=3'b010, mem_wr=0. mem_wr is also gated by rst_n
//   combinationally: no write ever occurs in a cycle with rst_n=0.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. One transaction per 3 cycles max.
//   IDLE: if any req, grant winner (gnt high same cycle); latch we/ctrl/addr/wdata/id/err_flag;
//         update rr_last=winner; -> ACCESS. No req: stay IDLE, gnt=0.
//   ACCESS: drive mem_* from latches; mem_wr = we & ~err_flag; capture mem_rdata (load, no err)
//           into rdata reg at end of cycle, else rdata=0; -> RESP.
//   RESP: rvalid/err/rdata presented to latched requester only, exactly one cycle; -> IDLE.
//         Other requester's outputs stay 0. No grant issued in RESP or ACCESS.
//  Arbitration: only one req -> it wins. Both -> the one != rr_last. Starvation bound: a held req
//   is granted within 2 transactions (<=6 cycles).
//  err_flag (checked in IDLE on winner's fields), any of:
//   - ctrl in {011,110,111}; ctrl in {100,101} with we=1
//   - H/HU with addr[0]=1; W with addr[1:0]!=0
//   - addr >= MEM_WORDS*4 (includes upper bits set)
//   Errored transaction: no memory write, rdata=0, err=1, still full 3-cycle sequence.
//  Idle mem bus (IDLE/RESP): mem_wr=0, mem_ctrl=010, addr/wdata hold last value.
//  Reset mid-transaction: aborted, no rvalid issued; if in ACCESS, write suppressed by gating.
//  req dropped before gnt: allowed, no effect. req held after rvalid: treated as new request.
// STRUCTURE
//  Package dmem_pkg: dmctrl_e enum (DM_B=000, DM_H=001, DM_W=010, DM_BU=100, DM_HU=101),
//   arb_state_e (IDLE, ACCESS, RESP), localparam for error-check helper function.
//  Sub-module rr_arb2: 2-way round-robin (req[1:0], rr_last, en -> gnt[1:0]); rest inline.
// TESTING
//  1 m0 SW addr 0x10 data 0xDEADBEEF, then m0 LW 0x10 -> gnt cycle0, mem_wr=1 cycle1 only,
//    rvalid cycle2 err=0; load returns 0xDEADBEEF.
//  2 m0,m1 both req LW same cycle after reset -> m0 granted first, m1 granted at IDLE 3 cycles
//    later; with both held continuously grants alternate 0,1,0,1.
//  3 m1 SH addr 0x21 / m0 LW 0x22 / m0 LBU we=1 / m0 ctrl 011 -> each err=1, rdata=0, mem_wr never 1.
//  4 m0 SW addr 0x400 (MEM_WORDS=256) -> err=1, no write; m0 LW 0x3FC -> err=0.
//  5 m0 SB 0x13 data 0x80 over word 0x0; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080.
//  6 rst_n low during ACCESS of a SW -> mem_wr=0 that cycle, no rvalid, memory word unchanged,
//    all outputs at reset values next cycle; next req from m0 wins.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data-memory arbiter.
//   dmctrl_e     : DataMemory DMCtrl access-size codes
//   arb_state_e  : arbiter FSM states
//   DM_IDLE_CTRL : DMCtrl value parked on the bus when no access is in flight
//   dm_check_err : opcode / alignment / range legality check for one request
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [2:0] {
        DM_B  = 3'b000,
        DM_H  = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dmctrl_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic [2:0] DM_IDLE_CTRL = DM_W;

    // Returns 1 when the request must not touch memory: unknown DMCtrl code,
    // unsigned-load code used for a store, misaligned half/word, or address
    // outside the memory (range test done by the caller, which knows XLEN).
    function automatic logic dm_check_err(input logic       we,
                                          input logic [2:0] ctrl,
                                          input logic [1:0] addr_lo,
                                          input logic       out_of_range);
        logic e;
        e = out_of_range;
        case (ctrl)
            DM_B:    e = e;
            DM_H:    e = e | addr_lo[0];
            DM_W:    e = e | (addr_lo != 2'b00);
            DM_BU:   e = e | we;
            DM_HU:   e = e | we | addr_lo[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
//   req_i[1:0]  in  : request vector (bit N = requester N)
//   rr_last_i   in  : index of the requester granted most recently
//   en_i        in  : grant enable; gnt_o is 0 when low
//   gnt_o[1:0]  out : one-hot grant (or zero)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                // Tie goes to whoever did not win last time.
                2'b11:   gnt_o = rr_last_i ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single DataMemory port between m0 (core LSU) and m1 (DMA/debug
// loader). Each transaction runs IDLE (grant) -> ACCESS (memory cycle) ->
// RESP (one-cycle response pulse to the owner).
//   clk, rst_n           : clock, synchronous active-low reset
//   mN_req/we/ctrl/      : requester N command; fields held until mN_gnt
//   mN_addr/wdata
//   mN_gnt               : combinational accept, fields captured on this edge
//   mN_rvalid/rdata/err  : response, valid for exactly one cycle
//   mem_addr/wdata/wr/   : DataMemory Address/DataWr/DMWr/DMCtrl
//   mem_ctrl
//   mem_rdata            : DataMemory DataRd (combinational read)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [2:0]      m0_ctrl,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [XLEN-1:0] m0_rdata,
    output logic            m0_err,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [2:0]      m1_ctrl,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [XLEN-1:0] m1_rdata,
    output logic            m1_err,

    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_wr,
    output logic [2:0]      mem_ctrl,
    input  logic [XLEN-1:0] mem_rdata
);

    arb_state_e      state_q;
    logic            rr_last_q;
    logic            id_q;
    logic            we_q;
    logic            err_q;
    logic [2:0]      ctrl_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] rdata_d;
    logic [1:0]      rvalid_q;

    logic [1:0]      gnt;
    logic            win;
    logic            w_we;
    logic [2:0]      w_ctrl;
    logic [XLEN-1:0] w_addr;
    logic [XLEN-1:0] w_wdata;
    logic            w_oor;
    logic            w_err;

    // Grants only from IDLE and never while reset is asserted.
    rr_arb2 u_rr_arb2 (
        .req_i     ({m1_req, m0_req}),
        .rr_last_i (rr_last_q),
        .en_i      (rst_n && (state_q == IDLE)),
        .gnt_o     (gnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    assign win     = gnt[1];
    assign w_we    = win ? m1_we    : m0_we;
    assign w_ctrl  = win ? m1_ctrl  : m0_ctrl;
    assign w_addr  = win ? m1_addr  : m0_addr;
    assign w_wdata = win ? m1_wdata : m0_wdata;

    // Widen to 64 bits so any set upper address bit counts as out of range.
    assign w_oor = (64'(w_addr) >= (64'(MEM_WORDS) * 64'd4));
    assign w_err = dm_check_err(w_we, w_ctrl, w_addr[1:0], w_oor);

    // Only error-free loads return data; stores and errors respond with 0.
    assign rdata_d = (!we_q && !err_q) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            ctrl_q    <= DM_IDLE_CTRL;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    rvalid_q <= 2'b00;
                    if (|gnt) begin
                        id_q      <= win;
                        we_q      <= w_we;
                        ctrl_q    <= w_ctrl;
                        addr_q    <= w_addr;
                        wdata_q   <= w_wdata;
                        err_q     <= w_err;
                        rr_last_q <= win;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= id_q ? 2'b10 : 2'b01;
                    state_q  <= RESP;
                end
                RESP: begin
                    rvalid_q <= 2'b00;
                    state_q  <= IDLE;
                end
                default: begin
                    rvalid_q <= 2'b00;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // Address/data hold their last value between accesses; write strobe is
    // additionally gated by rst_n so an abort in ACCESS cannot write.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_ctrl  = (state_q == ACCESS) ? ctrl_q : DM_IDLE_CTRL;
    assign mem_wr    = rst_n && (state_q == ACCESS) && we_q && !err_q;

    assign m0_rvalid = rvalid_q[0];
    assign m0_err    = rvalid_q[0] & err_q;
    assign m0_rdata  = rvalid_q[0] ? rdata_q : '0;
    assign m1_rvalid = rvalid_q[1];
    assign m1_err    = rvalid_q[1] & err_q;
    assign m1_rdata  = rvalid_q[1] ? rdata_q : '0;

endmodule
